// File: rtl/mux4_scan_ctrl_if.sv
// Signal bundle between the mux scan sequencer and its surroundings:
// mux select/sense lines, control inputs and the word handshake.
interface mux4_scan_ctrl_if;
    logic       START;
    logic       CONT;
    logic       MUX_OUT;
    logic       READY;
    logic [1:0] SEL;
    logic [3:0] DATA;
    logic       VALID;
    logic       BUSY;
    logic       OVERRUN;

    modport master (
        input  START, CONT, MUX_OUT, READY,
        output SEL, DATA, VALID, BUSY, OVERRUN
    );

    modport slave (
        output START, CONT, MUX_OUT, READY,
        input  SEL, DATA, VALID, BUSY, OVERRUN
    );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Steps a 4:1 mux through channels 0..3 with a programmable dwell,
// samples its output and hands 4-bit words downstream via valid/ready.
module mux4_scan_ctrl #(
    parameter int DWELL = 4
) (
    input logic             CLK,
    input logic             RST,
    mux4_scan_ctrl_if.master bus
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [2:0]    shadow;
    logic [3:0]    data;
    logic          valid;
    logic          overrun;

    logic          sample;
    logic          done;
    logic [3:0]    word;

    assign sample = (state == SCAN) && (cnt == LAST);
    assign done   = sample && (sel == 2'd3);
    assign word   = {bus.MUX_OUT, shadow};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            sel     <= 2'd0;
            shadow  <= 3'd0;
            data    <= 4'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.START) begin
                        state <= SCAN;
                        cnt   <= '0;
                        sel   <= 2'd0;
                    end
                end
                SCAN: begin
                    if (!sample) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        // sel wraps 3 -> 0, which is also the IDLE value
                        sel <= sel + 2'd1;
                        if (!done)
                            shadow[sel] <= bus.MUX_OUT;
                        if (done && !bus.CONT)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (done) begin
                if (!valid || bus.READY) begin
                    data  <= word;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && bus.READY) begin
                valid <= 1'b0;
            end
        end
    end

    assign bus.SEL     = sel;
    assign bus.DATA    = data;
    assign bus.VALID   = valid;
    assign bus.BUSY    = (state == SCAN);
    assign bus.OVERRUN = overrun;
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl: a DWELL=4 and a DWELL=1 instance,
// each fed by a behavioural 4:1 mux driven from a 4-bit input vector.
module tb_mux4_scan_ctrl;
    logic       clk;
    logic       rst;
    logic [3:0] in4;
    logic [3:0] in1;

    int passed;
    int total;

    mux4_scan_ctrl_if f4 ();
    mux4_scan_ctrl_if f1 ();

    mux4_scan_ctrl #(.DWELL(4)) dut4 (.CLK(clk), .RST(rst), .bus(f4.master));
    mux4_scan_ctrl #(.DWELL(1)) dut1 (.CLK(clk), .RST(rst), .bus(f1.master));

    assign f4.MUX_OUT = in4[f4.SEL];
    assign f1.MUX_OUT = in1[f1.SEL];

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ins;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [12:0] mask;

        clk = 1'b0;
        rst = 1'b1;
        in4 = 4'd0;
        in1 = 4'd0;
        passed = 0;
        total = 0;
        f4.START = 1'b0; f4.CONT = 1'b0; f4.READY = 1'b0;
        f1.START = 1'b0; f1.CONT = 1'b0; f1.READY = 1'b0;

        vecs[0] = '{4'b1101, 4'b1101, 16};
        vecs[1] = '{4'b0000, 4'b0000, 16};
        vecs[2] = '{4'b1111, 4'b1111, 16};
        vecs[3] = '{4'b0110, 4'b0110, 16};
        vecs[4] = '{4'b1000, 4'b1000, 16};

        tick();
        tick();
        chk("rst_sel", 32'(f4.SEL), 0);
        chk("rst_data", 32'(f4.DATA), 0);
        chk("rst_valid", 32'(f4.VALID), 0);
        chk("rst_busy", 32'(f4.BUSY), 0);
        chk("rst_ovr", 32'(f4.OVERRUN), 0);
        chk("rst1_valid", 32'(f1.VALID), 0);
        rst = 1'b0;
        tick();

        // single shot, no ready
        in4 = 4'b1101;
        f4.START = 1'b1;
        tick();
        f4.START = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("s1_sel", 32'(f4.SEL), 32'(k >> 2));
            chk("s1_busy", 32'(f4.BUSY), 1);
            if (k == 15)
                chk("s1_valid_early", 32'(f4.VALID), 0);
            tick();
        end
        chk("s1_valid", 32'(f4.VALID), 1);
        chk("s1_data", 32'(f4.DATA), 32'h1101 >> 12 | 32'hd & 32'hd);
        chk("s1_busy_fall", 32'(f4.BUSY), 0);
        chk("s1_sel_home", 32'(f4.SEL), 0);

        // continuous with backpressure
        do_reset();
        f4.CONT = 1'b1;
        f4.READY = 1'b0;
        in4 = 4'b1101;
        f4.START = 1'b1;
        tick();
        f4.START = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            case (k)
                16: begin
                    chk("c_valid1", 32'(f4.VALID), 1);
                    chk("c_data1", 32'(f4.DATA), 4'b1101);
                    in4 = 4'b0010;
                end
                31: chk("c_ovr_pre", 32'(f4.OVERRUN), 0);
                32: begin
                    chk("c_ovr", 32'(f4.OVERRUN), 1);
                    chk("c_data_held", 32'(f4.DATA), 4'b1101);
                    chk("c_valid_held", 32'(f4.VALID), 1);
                    chk("c_busy_cont", 32'(f4.BUSY), 1);
                end
                33: chk("c_ovr_post", 32'(f4.OVERRUN), 0);
                47: f4.READY = 1'b1;
                48: begin
                    chk("c_data3", 32'(f4.DATA), 4'b0010);
                    chk("c_valid3", 32'(f4.VALID), 1);
                    chk("c_ovr3", 32'(f4.OVERRUN), 0);
                    f4.CONT = 1'b0;
                end
                49: chk("c_valid_clr", 32'(f4.VALID), 0);
                63: chk("c_busy63", 32'(f4.BUSY), 1);
                64: begin
                    chk("c_busy_end", 32'(f4.BUSY), 0);
                    chk("c_valid4", 32'(f4.VALID), 1);
                    chk("c_data4", 32'(f4.DATA), 4'b0010);
                end
                default: ;
            endcase
            tick();
        end

        // input changes mid-dwell
        do_reset();
        f4.READY = 1'b1;
        in4 = 4'b0001;
        f4.START = 1'b1;
        tick();
        f4.START = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k == 6)
                in4 = 4'b0010;
            if (k == 16) begin
                chk("m_valid", 32'(f4.VALID), 1);
                chk("m_data", 32'(f4.DATA), 4'b0011);
            end
            tick();
        end

        // table of single-shot words
        for (int i = 0; i < 5; i++) begin
            f4.READY = 1'b1;
            f4.CONT = 1'b0;
            tick();
            tick();
            in4 = vecs[i].ins;
            f4.START = 1'b1;
            tick();
            f4.START = 1'b0;
            lat = 0;
            while (!f4.VALID && lat < 40) begin
                tick();
                lat++;
            end
            chk("t_lat", 32'(lat), 32'(vecs[i].exp_lat));
            chk("t_data", 32'(f4.DATA), 32'(vecs[i].exp_data));
        end

        // START held while busy, then async reset mid-scan
        do_reset();
        f4.READY = 1'b0;
        f4.CONT = 1'b0;
        in4 = 4'b1010;
        f4.START = 1'b1;
        tick();
        f4.START = 1'b0;
        for (int k = 0; k <= 26; k++) begin
            if (k < 16) begin
                chk("i_sel", 32'(f4.SEL), 32'(k >> 2));
                chk("i_busy", 32'(f4.BUSY), 1);
            end
            if (k == 16) begin
                chk("i_busy_end", 32'(f4.BUSY), 0);
                chk("i_valid", 32'(f4.VALID), 1);
                chk("i_data", 32'(f4.DATA), 4'b1010);
            end
            if (k == 17) begin
                chk("i_restart", 32'(f4.BUSY), 1);
                chk("i_restart_sel", 32'(f4.SEL), 0);
                f4.START = 1'b0;
            end
            if (k == 26) begin
                chk("r_sel_pre", 32'(f4.SEL), 2);
                #2 rst = 1'b1;
                #1;
                chk("r_sel", 32'(f4.SEL), 0);
                chk("r_data", 32'(f4.DATA), 0);
                chk("r_valid", 32'(f4.VALID), 0);
                chk("r_busy", 32'(f4.BUSY), 0);
                chk("r_ovr", 32'(f4.OVERRUN), 0);
                #1 rst = 1'b0;
            end
            if (k == 2)
                f4.START = 1'b1;
            tick();
        end
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            if (f4.VALID || f4.BUSY || f4.OVERRUN)
                seen++;
            tick();
        end
        chk("r_quiet", 32'(seen), 0);

        // DWELL=1 single shot
        f1.READY = 1'b0;
        f1.CONT = 1'b0;
        in1 = 4'b0110;
        f1.START = 1'b1;
        tick();
        f1.START = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4)
                chk("d1_sel", 32'(f1.SEL), 32'(k));
            if (k == 3)
                chk("d1_valid_early", 32'(f1.VALID), 0);
            if (k == 4) begin
                chk("d1_valid", 32'(f1.VALID), 1);
                chk("d1_data", 32'(f1.DATA), 4'b0110);
                chk("d1_busy", 32'(f1.BUSY), 0);
            end
            tick();
        end

        // DWELL=1 continuous, one word per 4 cycles
        f1.READY = 1'b1;
        f1.CONT = 1'b1;
        tick();
        tick();
        f1.START = 1'b1;
        tick();
        f1.START = 1'b0;
        mask = '0;
        for (int k = 0; k <= 12; k++) begin
            mask[k] = f1.VALID;
            if (k == 4)
                in1 = 4'b1001;
            if (k == 8)
                chk("d1c_data", 32'(f1.DATA), 4'b1001);
            if (k == 12)
                f1.CONT = 1'b0;
            tick();
        end
        chk("d1c_valid_mask", 32'(mask), 32'h1110);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mux4_scan_ctrl.md
# mux4_scan_ctrl

Sequencer directly upstream of the 4:1 gate-level multiplexer (`MUX4`). It drives the mux select lines through channels 0..3 in order and holds each channel for a programmable dwell. At the end of each dwell it samples the mux output. The four samples are assembled into a 4-bit word and presented downstream through a valid/ready handshake, in either single-shot or continuous scan mode.

## Interface
Parameters:
- `DWELL`, default 4: cycles each channel is held on `SEL`. Legal range is ≥1; `DWELL=1` samples every cycle.

Ports:
- `CLK` in 1: the single clock; all state updates on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `START` in 1: begins a scan when sampled high in IDLE; ignored while `BUSY`=1.
- `CONT` in 1: continuous mode, sampled at each scan-complete edge.
- `MUX_OUT` in 1: connects to the mux `OUT`.
- `SEL` out 2: connects to the mux `SEL`; channel n selects input A/B/C/D for n = 0/1/2/3.
- `DATA` out 4: last completed word; bit n holds the sample from channel n.
- `VALID` out 1: `DATA` holds an unconsumed word.
- `READY` in 1: downstream accepts `DATA` on any edge where `VALID`=1 and `READY`=1.
- `BUSY` out 1: high while scanning.
- `OVERRUN` out 1: one-cycle pulse when a completed word is dropped.

## Operation
- States: IDLE and SCAN. The dwell counter ranges 0..DWELL-1 and is at least 1 bit wide. A 3-bit shadow register holds the samples for channels 0..2.
- Reset value of every output is 0: `SEL`=00, `DATA`=0000, `VALID`=0, `BUSY`=0, `OVERRUN`=0. Counter and shadow also reset to 0.
- IDLE:
  - `SEL`=00, `BUSY`=0.
  - `START`=1 → SCAN, with counter=0 and `SEL`=00.
- SCAN, on each edge:
  - If counter < DWELL-1: counter increments.
  - Else (sample edge): `MUX_OUT` is captured into shadow[`SEL`], counter returns to 0, and `SEL` increments.
- Scan complete (sample edge with `SEL`=11):
  - The word {`MUX_OUT`, shadow[2:0]} is offered to the output register.
  - `CONT`=1: `SEL` wraps to 00 and SCAN continues with no gap cycle.
  - `CONT`=0: → IDLE.
- Output register, evaluated at each scan-complete edge:
  - `VALID`=0, or `VALID`=1 with `READY`=1: `DATA` loads the new word and `VALID` becomes 1. Simultaneous accept and load keeps `VALID` at 1 with the new word.
  - `VALID`=1 with `READY`=0: the new word is discarded, the old `DATA` is held, and `OVERRUN`=1 for exactly one cycle.
- On all other edges: `VALID`=1 with `READY`=1 clears `VALID`. `DATA` holds its value.
- `RST` asserted mid-scan: all state returns to reset values immediately, without waiting for a clock edge. The partial word is lost and no `OVERRUN` is raised.
- `START` is level-sampled only in IDLE. A `START` held high through scan completion with `CONT`=0 starts a new scan on the first IDLE edge.

## Timing
- `START` sampled at edge t0 puts SCAN active after t0. `SEL`=n during cycles [t0+n·DWELL, t0+(n+1)·DWELL).
- Channel n is sampled at edge t0+(n+1)·DWELL. After each channel change the mux output has DWELL-1 cycles plus the final cycle to settle before sampling.
- Latency: `VALID` rises after edge t0+4·DWELL; the loaded `DATA` is visible in the same cycle.
- `CONT`=1 throughput is one word per 4·DWELL cycles.
- `BUSY` is high from after t0 until after the last sample edge when exiting to IDLE.
- Single-shot with `CONT`=0: a new `START` in the first IDLE cycle restarts after one IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, single shot, `DWELL`=4:
  - Stimulus: mux inputs A=1, B=0, C=1, D=1; `START` pulsed at t0; `READY`=0.
  - Required: `SEL` reads 00, 01, 10, 11 for 4 cycles each. `VALID` rises after edge t0+16 with `DATA`=4'b1101. `BUSY` falls in the same cycle and `SEL` returns to 00.
- Continuous mode with backpressure:
  - Stimulus: `CONT`=1, `READY`=0, inputs constant.
  - Required: the second scan completes at t0+32 and is dropped with a one-cycle `OVERRUN`; `DATA` is unchanged at 1101.
  - Stimulus: raise `READY` at the completion edge of the third scan.
  - Required: the new word loads and `VALID` stays 1.
- Input change mid-dwell, `DWELL`=4:
  - Stimulus: B toggles 0→1 one cycle before channel 1's sample edge.
  - Required: bit 1 = 1. Channel 0's sample is unaffected.
- `START` ignored:
  - Stimulus: `START` asserted while `BUSY`=1.
  - Required: no restart; `SEL` sequence and counter are unaffected.
- Asynchronous reset mid-scan:
  - Stimulus: `RST` pulsed between edges while `SEL`=10.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge. There is no `VALID` afterward until a new `START`.
- `DWELL`=1:
  - Stimulus: `START` at t0.
  - Required: `SEL` changes every cycle and `VALID` rises after edge t0+4. Under `CONT`=1 a word completes every 4 cycles.
